osc_div_multi: RTL

//  Synthesisable multi-channel clock-enable/divided-clock generator; successor to the fixed on-chip oscillator model.

---
 rtl/osc_div_pkg.sv | 24 ++
 rtl/osc_div_multi_if.sv | 29 ++
 rtl/osc_div_chan.sv | 64 ++++++
 rtl/osc_div_multi.sv | 110 +++++++++++
 4 files changed

// File: rtl/osc_div_pkg.sv
// Shared types and helpers for the multi-channel divided-clock generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package osc_div_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_STOP
  } osc_st_t;

  localparam int OSC_DIV_MIN = 2;

  // Ratios 0 and 1 cannot produce a 50%-ish clock, so they run as divide-by-2.
  function automatic int div_clamp(input int n);
    return (n < OSC_DIV_MIN) ? OSC_DIV_MIN : n;
  endfunction

  // High-phase length ceil(n/2): odd ratios stay high one cycle longer.
  function automatic int half_hi(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/osc_div_multi_if.sv
// Control and output bundle of osc_div_multi (master = controller, slave = generator).
// Latency: n/a (wires only).
// Backpressure: none; loads are single-cycle strobes, outputs are free-running.
interface osc_div_multi_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              stdby;
  logic              div_load;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] osc;
  logic [NUM_CH-1:0] osc_tick;
  logic              stdby_ack;
  logic              sedstdby;
  logic              oscesb;

  modport master (
    output stdby, div_load, div_ch, div_val,
    input  osc, osc_tick, stdby_ack, sedstdby, oscesb
  );

  modport slave (
    input  stdby, div_load, div_ch, div_val,
    output osc, osc_tick, stdby_ack, sedstdby, oscesb
  );
endinterface

// File: rtl/osc_div_chan.sv
// One programmable divider channel: counter, pending/active ratio, park handshake.
// Latency: osc/tick registered, one cycle after the count they describe.
// Backpressure: none; a new ratio waits for the period boundary, park waits for it too.
module osc_div_chan
  import osc_div_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  input  logic             park_req,
  output logic             osc,
  output logic             tick,
  output logic             parked
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(div_clamp(DIV_INIT));

  // cnt is the count of the cycle the next edge will present on osc/tick.
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] pend_nxt;
  logic [CNT_W-1:0] div_use;
  logic [CNT_W-1:0] val_c;

  // Latest load wins; a load seen on the period-start edge applies to that period.
  always_comb begin
    val_c    = CNT_W'(div_clamp(int'(val)));
    pend_nxt = load ? val_c : pend;
    div_use  = (cnt == '0) ? pend_nxt : div;
  end

  // Count, swap in the pending ratio at period start, park only at a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      div    <= DIV_RST;
      pend   <= DIV_RST;
      osc    <= 1'b0;
      tick   <= 1'b0;
      parked <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (cnt == '0) begin
        div <= div_use;
      end
      if (park_req && (cnt == '0)) begin
        osc    <= 1'b0;
        tick   <= 1'b0;
        parked <= 1'b1;
      end else begin
        parked <= 1'b0;
        osc    <= (cnt < CNT_W'(half_hi(int'(div_use))));
        tick   <= (cnt == (div_use - 1'b1));
        cnt    <= (cnt == (div_use - 1'b1)) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/osc_div_multi.sv
// NUM_CH runtime-programmable divided clocks with glitch-free standby drain/stop; OSC_DIV_ESB_EN adds the fixed OSCESB clock.
// Latency: all outputs registered; first osc high one cycle after reset release, ack one cycle after last park.
// Backpressure: none; ratio loads accepted every cycle and applied at the next period start.
module osc_div_multi
  import osc_div_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 4,
  parameter int ESB_DIV  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  osc_div_multi_if.slave    bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  osc_st_t           state;
  logic              ack_q;
  logic              sed_q;
  logic              park_req;
  logic [NUM_CH-1:0] parked;
  logic [NUM_CH-1:0] osc_v;
  logic [NUM_CH-1:0] tick_v;

  // Channels are asked to park in DRAIN and stay parked through STOP.
  assign park_req = (state != ST_RUN);

  // Shared standby sequencer plus the plain standby delay for the SED block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      ack_q <= 1'b0;
      sed_q <= 1'b0;
    end else begin
      sed_q <= bus.stdby;
      unique case (state)
        ST_RUN: begin
          if (bus.stdby) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.stdby) begin
            state <= ST_RUN;
          end else if (&parked) begin
            state <= ST_STOP;
            ack_q <= 1'b1;
          end
        end
        ST_STOP: begin
          if (!bus.stdby) begin
            state <= ST_RUN;
            ack_q <= 1'b0;
          end
        end
        default: begin
          state <= ST_RUN;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    osc_div_chan #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (bus.div_load && (bus.div_ch == CH_W'(i))),
      .val      (bus.div_val),
      .park_req (park_req),
      .osc      (osc_v[i]),
      .tick     (tick_v[i]),
      .parked   (parked[i])
    );
  end

  assign bus.osc       = osc_v;
  assign bus.osc_tick  = tick_v;
  assign bus.stdby_ack = ack_q;
  assign bus.sedstdby  = sed_q;

`ifdef OSC_DIV_ESB_EN
  // Always-on side clock for SED: never loaded, never parked by standby.
  logic esb_osc;
  logic esb_tick;
  logic esb_parked;

  osc_div_chan #(
    .CNT_W    (CNT_W),
    .DIV_INIT (ESB_DIV)
  ) u_esb (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .val      ('0),
    .park_req (1'b0),
    .osc      (esb_osc),
    .tick     (esb_tick),
    .parked   (esb_parked)
  );

  assign bus.oscesb = esb_osc;
`else
  assign bus.oscesb = 1'b0;
`endif

endmodule
